// File: rtl/lsu_load_ctrl.sv
// Single-outstanding load controller: bus read, byte/halfword extraction, fault and timeout reporting.
// Optional build macro MISALIGNED_LOAD_TRAP_EN: misaligned H/HU/W loads fault instead of being force-aligned.
module lsu_load_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam logic [2:0] LOAD_B  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_W  = 3'b010;
  localparam logic [2:0] LOAD_BU = 3'b100;
  localparam logic [2:0] LOAD_HU = 3'b101;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  function automatic logic type_legal(input logic [2:0] t);
    logic ok;
    case (t)
      LOAD_B, LOAD_H, LOAD_W, LOAD_BU, LOAD_HU: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] align_off(input logic [2:0] t, input logic [1:0] off);
    logic [1:0] r;
    case (t)
      LOAD_H, LOAD_HU: r = {off[1], 1'b0};
      LOAD_W:          r = 2'b00;
      default:         r = off;
    endcase
    return r;
  endfunction

`ifdef MISALIGNED_LOAD_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
    logic m;
    case (t)
      LOAD_H, LOAD_HU: m = off[0];
      LOAD_W:          m = (off != 2'b00);
      default:         m = 1'b0;
    endcase
    return m;
  endfunction
`endif

  function automatic logic [31:0] extract_load(input logic [2:0] t, input logic [1:0] off,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'd0;
    endcase
    if (off[1]) begin
      h = w[31:16];
    end else begin
      h = w[15:0];
    end
    case (t)
      LOAD_B:  r = {{24{b[7]}}, b};
      LOAD_BU: r = {24'd0, b};
      LOAD_H:  r = {{16{h[15]}}, h};
      LOAD_HU: r = {16'd0, h};
      LOAD_W:  r = w;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Next-state, request latch, timeout counter and response capture.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    off_d   = off_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          type_d = req_type;
          off_d  = align_off(req_type, req_addr[1:0]);
          addr_d = {req_addr[31:2], 2'b00};
          cnt_d  = 8'd0;
          if (!type_legal(req_type)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            data_d  = 32'd0;
          end
`ifdef MISALIGNED_LOAD_TRAP_EN
          else if (is_misaligned(req_type, req_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            data_d  = 32'd0;
          end
`endif
          else begin
            state_d = ST_REQ;
            err_d   = 1'b0;
            data_d  = 32'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        // Data arriving in the final counted cycle still wins over the timeout.
        if (mem_rvalid) begin
          state_d = ST_RESP;
          data_d  = extract_load(type_q, off_q, mem_rdata);
          err_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RESP;
          data_d  = 32'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      cnt_q   <= 8'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_req    = (state_q == ST_REQ);
  assign mem_addr   = (state_q == ST_REQ) ? addr_q : 32'd0;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = data_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_load_ctrl.sv
// Directed plus randomized bench for lsu_load_ctrl against a word-level arithmetic load model.
module tb_lsu_load_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  lsu_load_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_addr(req_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Load semantics from the rules: size/sign by type, lane = aligned byte offset, arithmetic extension.
  function automatic void model(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd,
                                input int rv_dly, output bit nobus, output logic [31:0] d,
                                output bit e, output int wait_cyc);
    int     size;
    bit     sgn;
    int     off;
    longint v;
    size = 0;
    sgn  = 1'b0;
    case (t)
      3'd0:    begin size = 1; sgn = 1'b1; end
      3'd1:    begin size = 2; sgn = 1'b1; end
      3'd2:    size = 4;
      3'd4:    size = 1;
      3'd5:    size = 2;
      default: size = 0;
    endcase
    off   = int'(a % 32'd4);
    nobus = (size == 0);
`ifdef MISALIGNED_LOAD_TRAP_EN
    if (size != 0 && (off % size) != 0) nobus = 1'b1;
`endif
    d = 32'd0;
    e = 1'b1;
    wait_cyc = 0;
    if (nobus) return;
    off = off - (off % size);
    if (rv_dly >= TO) begin
      wait_cyc = TO;
      return;
    end
    wait_cyc = rv_dly + 1;
    v = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * size));
    if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
    d = 32'(v);
    e = 1'b0;
  endfunction

  // One complete load: request, bus handshake with junk on ignored strobes, response hold, release.
  task automatic run_load(input string nm, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] rd, input int gnt_dly, input int rv_dly,
                          input int rdy_dly, output logic [31:0] o_data, output bit o_err,
                          output int o_lat, output int o_nreq, output logic [31:0] o_addr);
    bit          nobus, e_err, granted;
    logic [31:0] e_data;
    int          wcyc, e_wait, lat, nreq;
    model(t, a, rd, rv_dly, nobus, e_data, e_err, e_wait);
    chk({nm, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_type = t; req_addr = a;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b0;
    step();
    req_valid = 1'b0; req_type = 3'($urandom); req_addr = $urandom;
    lat = 1; nreq = 0; granted = 1'b0; wcyc = 0; o_addr = 32'd0;
    while (!resp_valid && lat < 400) begin
      mem_gnt = 1'($urandom); mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (mem_req) begin
        if (nreq == 0) o_addr = mem_addr;
        mem_gnt    = (nreq == gnt_dly);
        mem_rvalid = 1'($urandom);
        if (mem_gnt) granted = 1'b1;
        nreq++;
      end else begin
        chk({nm, "_addr_idle0"}, mem_addr, 32'd0);
        if (granted) begin
          mem_rvalid = (wcyc == rv_dly);
          if (mem_rvalid) mem_rdata = rd;
          wcyc++;
        end
      end
      step();
      lat++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    o_data = resp_data; o_err = resp_err; o_lat = lat; o_nreq = nreq;
    chk({nm, "_latency"}, 32'(lat), nobus ? 32'd1 : 32'(2 + gnt_dly + e_wait));
    chk({nm, "_nreq"}, 32'(nreq), nobus ? 32'd0 : 32'(gnt_dly + 1));
    if (!nobus) chk({nm, "_mem_addr"}, o_addr, {a[31:2], 2'b00});
    chk({nm, "_data"}, resp_data, e_data);
    chk({nm, "_err"}, 32'(resp_err), 32'(e_err));
    for (int i = 0; i < rdy_dly; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      step();
      chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_hold_data"}, resp_data, e_data);
      chk({nm, "_hold_err"}, 32'(resp_err), 32'(e_err));
      chk({nm, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    mem_rvalid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({nm, "_release_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, "_release_rdy"}, 32'(req_ready), 32'd1);
  endtask

  logic [31:0] d, ad;
  bit          er;
  int          lt, nr;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_type = 3'd0; req_addr = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; resp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    run_load("lb", 3'd0, 32'h0000_1003, 32'h80FF_FF7F, 0, 0, 0, d, er, lt, nr, ad);
    chk("lb_const_data", d, 32'hFFFF_FF80);
    chk("lb_const_lat", 32'(lt), 32'd3);

    run_load("lhu", 3'd5, 32'h0000_2002, 32'h8001_1234, 4, 0, 0, d, er, lt, nr, ad);
    chk("lhu_const_data", d, 32'h0000_8001);
    chk("lhu_const_nreq", 32'(nr), 32'd5);
    chk("lhu_const_addr", ad, 32'h0000_2000);

    run_load("lw_to", 3'd2, 32'h0000_3000, 32'h1234_5678, 0, 999, 0, d, er, lt, nr, ad);
    chk("lw_to_err", 32'(er), 32'd1);
    chk("lw_to_lat", 32'(lt), 32'(2 + TO));

    run_load("lw_edge", 3'd2, 32'h0000_3000, 32'hCAFE_F00D, 1, TO - 1, 0, d, er, lt, nr, ad);
    chk("lw_edge_data", d, 32'hCAFE_F00D);

    run_load("lw_mis", 3'd2, 32'h0000_3001, 32'hDEAD_BEEF, 0, 0, 0, d, er, lt, nr, ad);
`ifdef MISALIGNED_LOAD_TRAP_EN
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_nreq", 32'(nr), 32'd0);
`else
    chk("lw_mis_data", d, 32'hDEAD_BEEF);
    chk("lw_mis_addr", ad, 32'h0000_3000);
    chk("lw_mis_err", 32'(er), 32'd0);
`endif

    run_load("hold", 3'd1, 32'h0000_4002, 32'h9ABC_0000, 0, 2, 5, d, er, lt, nr, ad);
    chk("hold_const_data", d, 32'hFFFF_9ABC);

    run_load("illegal", 3'd3, 32'h0000_5000, 32'h1111_1111, 0, 0, 1, d, er, lt, nr, ad);
    chk("illegal_err", 32'(er), 32'd1);

    // Reset while waiting for read data: the load is dropped without a response.
    req_valid = 1'b1; req_type = 3'd2; req_addr = 32'h0000_6000;
    step();
    req_valid = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_valid", 32'(resp_valid), 32'd0);
    chk("rstw_mem_req", 32'(mem_req), 32'd0);
    chk("rstw_data", resp_data, 32'd0);
    chk("rstw_err", 32'(resp_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = $urandom;
      step();
      chk("rstw_late_valid", 32'(resp_valid), 32'd0);
      chk("rstw_late_ready", 32'(req_ready), 32'd1);
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0;

    for (int n = 0; n < 60; n++) begin
      int rv;
      rv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 3))
                                      : int'($urandom_range(0, 4));
      run_load("rnd", 3'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)), rv,
               int'($urandom_range(0, 2)), d, er, lt, nr, ad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
